// File: rtl/hyp_seq_checker.sv
// Consumer-side checker for the hyperbolic CORDIC iteration-index stream.
// Verifies the 1..15 schedule with REP_A and REP_B issued twice, and reports done or the first violation.
module hyp_seq_checker #(
    parameter int IDX_W = 4,
    parameter int REP_A = 4,
    parameter int REP_B = 13,
    parameter int LAST  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             idx_valid,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] shift_amt,
    output logic             shift_vld,
    output logic             repeat_o,
    output logic [4:0]       step_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx,
    output logic [4:0]       err_step
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [IDX_W-1:0] C_REP_A    = IDX_W'(REP_A);
    localparam logic [IDX_W-1:0] C_REP_B    = IDX_W'(REP_B);
    localparam logic [IDX_W-1:0] C_LAST     = IDX_W'(LAST);
    localparam logic [IDX_W-1:0] C_FIRST    = IDX_W'(1);
    // Each index once, plus the two repeats.
    localparam logic [4:0]       C_FULL_RUN = 5'(LAST + 2);

    state_t           r_state;
    state_t           w_nextState;

    logic [IDX_W-1:0] r_exp;
    logic             r_repSeen;
    logic [IDX_W-1:0] r_shiftAmt;
    logic             r_shiftVld;
    logic             r_repeat;
    logic [4:0]       r_stepCnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [IDX_W-1:0] r_errIdx;
    logic [4:0]       r_errStep;

    logic             w_checking;
    logic             w_sample;
    logic             w_match;
    logic             w_expIsRep;
    logic             w_firstIssue;
    logic             w_accept;
    logic             w_violate;
    logic             w_finish;
    logic             w_postDoneBad;

    logic [IDX_W-1:0] w_expNxt;
    logic             w_repSeenNxt;
    logic [IDX_W-1:0] w_shiftAmtNxt;
    logic             w_shiftVldNxt;
    logic             w_repeatNxt;
    logic [4:0]       w_stepCntNxt;
    logic             w_busyNxt;
    logic             w_doneNxt;
    logic             w_errNxt;
    logic [IDX_W-1:0] w_errIdxNxt;
    logic [4:0]       w_errStepNxt;

    // start wins over a coincident idx_valid, so that index is never sampled.
    assign w_checking    = (r_state == ST_ARMED) || (r_state == ST_RUN);
    assign w_sample      = idx_valid && !start;
    assign w_match       = (idx == r_exp);
    assign w_expIsRep    = (r_exp == C_REP_A) || (r_exp == C_REP_B);
    assign w_firstIssue  = w_expIsRep && !r_repSeen;
    assign w_accept      = w_checking && w_sample && w_match;
    assign w_violate     = w_checking && w_sample && !w_match;
    assign w_finish      = w_accept && (idx == C_LAST) && !w_firstIssue;
    assign w_postDoneBad = (r_state == ST_DONE) && w_sample && (idx != C_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (start) begin
            w_nextState = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED, ST_RUN: begin
                    if (w_violate) begin
                        w_nextState = ST_ERROR;
                    end else if (w_finish) begin
                        w_nextState = ST_DONE;
                    end else if (w_accept) begin
                        w_nextState = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_postDoneBad) begin
                        w_nextState = ST_ERROR;
                    end
                end
                default: begin
                    w_nextState = r_state;
                end
            endcase
        end
    end

    always_comb begin
        w_expNxt      = r_exp;
        w_repSeenNxt  = r_repSeen;
        w_shiftAmtNxt = r_shiftAmt;
        w_shiftVldNxt = 1'b0;
        w_repeatNxt   = 1'b0;
        w_stepCntNxt  = r_stepCnt;
        w_doneNxt     = r_done;
        w_errNxt      = r_err;
        w_errIdxNxt   = r_errIdx;
        w_errStepNxt  = r_errStep;
        w_busyNxt     = (w_nextState == ST_ARMED) || (w_nextState == ST_RUN);

        if (start) begin
            w_expNxt     = C_FIRST;
            w_repSeenNxt = 1'b0;
            w_stepCntNxt = 5'd0;
            w_doneNxt    = 1'b0;
            w_errNxt     = 1'b0;
            w_errIdxNxt  = '0;
            w_errStepNxt = 5'd0;
        end else if (w_accept) begin
            w_shiftAmtNxt = idx;
            w_shiftVldNxt = 1'b1;
            w_repeatNxt   = w_expIsRep && r_repSeen;
            if (r_stepCnt != C_FULL_RUN) begin
                w_stepCntNxt = r_stepCnt + 5'd1;
            end
            // A first issue of a repeated index holds exp for its second issue.
            if (w_firstIssue) begin
                w_repSeenNxt = 1'b1;
            end else begin
                w_repSeenNxt = 1'b0;
                if (r_exp != C_LAST) begin
                    w_expNxt = r_exp + C_FIRST;
                end
            end
            if (w_finish) begin
                w_doneNxt = 1'b1;
            end
        end else if (w_violate) begin
            w_errNxt     = 1'b1;
            w_errIdxNxt  = idx;
            w_errStepNxt = r_stepCnt;
        end else if (w_postDoneBad) begin
            w_errNxt     = 1'b1;
            w_doneNxt    = 1'b0;
            w_errIdxNxt  = idx;
            w_errStepNxt = C_FULL_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exp      <= '0;
            r_repSeen  <= 1'b0;
            r_shiftAmt <= '0;
            r_shiftVld <= 1'b0;
            r_repeat   <= 1'b0;
            r_stepCnt  <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errIdx   <= '0;
            r_errStep  <= 5'd0;
        end else begin
            r_exp      <= w_expNxt;
            r_repSeen  <= w_repSeenNxt;
            r_shiftAmt <= w_shiftAmtNxt;
            r_shiftVld <= w_shiftVldNxt;
            r_repeat   <= w_repeatNxt;
            r_stepCnt  <= w_stepCntNxt;
            r_busy     <= w_busyNxt;
            r_done     <= w_doneNxt;
            r_err      <= w_errNxt;
            r_errIdx   <= w_errIdxNxt;
            r_errStep  <= w_errStepNxt;
        end
    end

    assign shift_amt = r_shiftAmt;
    assign shift_vld = r_shiftVld;
    assign repeat_o  = r_repeat;
    assign step_cnt  = r_stepCnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_idx   = r_errIdx;
    assign err_step  = r_errStep;

endmodule

// File: tb/tb_hyp_seq_checker.sv
// Testbench for hyp_seq_checker: scenario tasks compared against a schedule-position reference model.
// The model walks a list of expected indices; a repeat is an index equal to its predecessor in that list.
module tb_hyp_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       idx_valid = 1'b0;
    logic [3:0] idx = 4'd0;
    logic [3:0] shift_amt;
    logic       shift_vld;
    logic       repeat_o;
    logic [4:0] step_cnt;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] err_idx;
    logic [4:0] err_step;

    int nChecks = 0;
    int nFails = 0;

    logic [3:0] sched[$];

    int         m_phase;
    int         m_pos;
    logic       m_shiftVld;
    logic       m_repeat;
    logic       m_busy;
    logic       m_done;
    logic       m_err;
    logic [3:0] m_shiftAmt;
    logic [3:0] m_errIdx;
    logic [4:0] m_stepCnt;
    logic [4:0] m_errStep;

    hyp_seq_checker dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .idx_valid (idx_valid),
        .idx       (idx),
        .shift_amt (shift_amt),
        .shift_vld (shift_vld),
        .repeat_o  (repeat_o),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_idx   (err_idx),
        .err_step  (err_step)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] dutVec();
        return {shift_vld, repeat_o, shift_amt, step_cnt, busy, done, err, err_idx, err_step};
    endfunction

    function automatic logic [22:0] modelVec();
        return {m_shiftVld, m_repeat, m_shiftAmt, m_stepCnt, m_busy, m_done, m_err, m_errIdx, m_errStep};
    endfunction

    // phase: 0 idle, 1 checking, 2 schedule complete, 3 violated
    task automatic modelReset();
        m_phase    = 0;
        m_pos      = 0;
        m_shiftVld = 1'b0;
        m_repeat   = 1'b0;
        m_busy     = 1'b0;
        m_done     = 1'b0;
        m_err      = 1'b0;
        m_shiftAmt = 4'd0;
        m_errIdx   = 4'd0;
        m_stepCnt  = 5'd0;
        m_errStep  = 5'd0;
    endtask

    task automatic modelClock(input logic st, input logic v, input logic [3:0] ix);
        m_shiftVld = 1'b0;
        m_repeat   = 1'b0;
        if (st) begin
            m_phase   = 1;
            m_pos     = 0;
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_errIdx  = 4'd0;
            m_errStep = 5'd0;
        end else if (v && m_phase == 1) begin
            if (ix == sched[m_pos]) begin
                m_shiftVld = 1'b1;
                m_shiftAmt = ix;
                m_repeat   = (m_pos > 0) && (sched[m_pos-1] == ix);
                m_pos      = m_pos + 1;
                if (m_pos == sched.size()) begin
                    m_phase = 2;
                    m_done  = 1'b1;
                end
            end else begin
                m_phase   = 3;
                m_err     = 1'b1;
                m_errIdx  = ix;
                m_errStep = 5'(m_pos);
            end
        end else if (v && m_phase == 2 && ix != 4'd15) begin
            m_phase   = 3;
            m_err     = 1'b1;
            m_done    = 1'b0;
            m_errIdx  = ix;
            m_errStep = 5'd17;
        end
        m_stepCnt = 5'(m_pos);
        m_busy    = (m_phase == 1);
    endtask

    task automatic applyStimulus(input logic st, input logic v, input logic [3:0] ix);
        @(negedge clk);
        start     = st;
        idx_valid = v;
        idx       = ix;
        @(posedge clk);
        modelClock(st, v, ix);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        modelReset();
        #12;
        nChecks++;
        if (dutVec() !== 23'd0) begin
            nFails++;
            $display("[TB] FAIL reset_values: got %h expected %h", dutVec(), 23'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'(i + 1));
            nChecks++;
            if (dutVec() !== modelVec() || shift_vld !== 1'b0 || busy !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL idle_ignores_valid: got %h expected %h", dutVec(), modelVec());
            end
        end
    endtask

    task automatic test_legal_run();
        int nVld = 0;
        logic [17:0] repSteps = '0;
        applyStimulus(1'b1, 1'b0, 4'd0);
        nChecks++;
        if (busy !== 1'b1 || step_cnt !== 5'd0 || dutVec() !== modelVec()) begin
            nFails++;
            $display("[TB] FAIL armed_after_start: got %h expected %h", dutVec(), modelVec());
        end
        for (int i = 0; i < sched.size(); i++) begin
            applyStimulus(1'b0, 1'b1, sched[i]);
            if (shift_vld === 1'b1) nVld++;
            if (repeat_o === 1'b1) repSteps[i+1] = 1'b1;
            nChecks++;
            if (dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL legal_step %0d: got %h expected %h", i + 1, dutVec(), modelVec());
            end
        end
        nChecks++;
        if (nVld != 17) begin
            nFails++;
            $display("[TB] FAIL legal_pulse_count: got %0d expected 17", nVld);
        end
        nChecks++;
        if (repSteps !== 18'((1 << 5) | (1 << 15))) begin
            nFails++;
            $display("[TB] FAIL legal_repeat_steps: got %h expected %h", repSteps, 18'((1 << 5) | (1 << 15)));
        end
        nChecks++;
        if (done !== 1'b1 || step_cnt !== 5'd17 || busy !== 1'b0 || err !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL legal_done: got done=%b cnt=%0d busy=%b err=%b expected 1 17 0 0", done, step_cnt, busy, err);
        end
    endtask

    task automatic test_missing_repeat();
        logic [3:0] seq[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        applyStimulus(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, seq[i]);
            nChecks++;
            if (dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL missing_repeat_step %0d: got %h expected %h", i, dutVec(), modelVec());
            end
        end
        nChecks++;
        if (err !== 1'b1 || err_idx !== 4'd5 || err_step !== 5'd4 || shift_vld !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL missing_repeat_err: got err=%b idx=%0d step=%0d vld=%b expected 1 5 4 0", err, err_idx, err_step, shift_vld);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)));
            nChecks++;
            if (dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL error_sticky: got %h expected %h", dutVec(), modelVec());
            end
        end
    endtask

    task automatic test_gapped_terminal();
        applyStimulus(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < sched.size(); i++) begin
            int gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 4'($urandom_range(0, 15)));
                nChecks++;
                if (dutVec() !== modelVec()) begin
                    nFails++;
                    $display("[TB] FAIL gap_idle: got %h expected %h", dutVec(), modelVec());
                end
            end
            applyStimulus(1'b0, 1'b1, sched[i]);
            nChecks++;
            if (dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL gapped_step %0d: got %h expected %h", i + 1, dutVec(), modelVec());
            end
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd15);
            nChecks++;
            if (done !== 1'b1 || err !== 1'b0 || shift_vld !== 1'b0 || dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL terminal_hold: got %h expected %h", dutVec(), modelVec());
            end
        end
        applyStimulus(1'b0, 1'b1, 4'd3);
        nChecks++;
        if (err !== 1'b1 || err_step !== 5'd17 || done !== 1'b0 || err_idx !== 4'd3) begin
            nFails++;
            $display("[TB] FAIL post_done_err: got err=%b step=%0d done=%b idx=%0d expected 1 17 0 3", err, err_step, done, err_idx);
        end
    endtask

    task automatic test_restart_priority();
        applyStimulus(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, sched[i]);
        applyStimulus(1'b1, 1'b0, 4'd0);
        nChecks++;
        if (step_cnt !== 5'd0 || busy !== 1'b1 || done !== 1'b0 || dutVec() !== modelVec()) begin
            nFails++;
            $display("[TB] FAIL restart_mid_run: got %h expected %h", dutVec(), modelVec());
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, sched[i]);
        applyStimulus(1'b1, 1'b1, 4'd8);
        nChecks++;
        if (step_cnt !== 5'd0 || shift_vld !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL start_priority: got cnt=%0d vld=%b busy=%b err=%b expected 0 0 1 0", step_cnt, shift_vld, busy, err);
        end
        for (int i = 0; i < sched.size(); i++) begin
            applyStimulus(1'b0, 1'b1, sched[i]);
            nChecks++;
            if (dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL restart_run_step %0d: got %h expected %h", i + 1, dutVec(), modelVec());
            end
        end
        nChecks++;
        if (done !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL restart_done: got %b expected 1", done);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, sched[i]);
        @(negedge clk);
        idx_valid = 1'b0;
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (dutVec() !== 23'd0) begin
            nFails++;
            $display("[TB] FAIL async_reset: got %h expected %h", dutVec(), 23'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, sched[i]);
            nChecks++;
            if (shift_vld !== 1'b0 || busy !== 1'b0 || step_cnt !== 5'd0 || dutVec() !== modelVec()) begin
                nFails++;
                $display("[TB] FAIL needs_start: got %h expected %h", dutVec(), modelVec());
            end
        end
    endtask

    task automatic test_early_late();
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd2);
        nChecks++;
        if (err !== 1'b1 || err_idx !== 4'd2 || err_step !== 5'd0 || dutVec() !== modelVec()) begin
            nFails++;
            $display("[TB] FAIL early_index: got idx=%0d step=%0d expected 2 0", err_idx, err_step);
        end
        applyStimulus(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, sched[i]);
        applyStimulus(1'b0, 1'b1, 4'd13);
        nChecks++;
        if (err !== 1'b1 || err_idx !== 4'd13 || err_step !== 5'd15 || dutVec() !== modelVec()) begin
            nFails++;
            $display("[TB] FAIL third_repeat: got idx=%0d step=%0d expected 13 15", err_idx, err_step);
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 8; run++) begin
            applyStimulus(1'b1, 1'b0, 4'd0);
            for (int c = 0; c < 30; c++) begin
                logic       st = ($urandom_range(0, 59) == 0);
                logic       v = ($urandom_range(0, 3) != 0);
                logic [3:0] ix = (m_pos < sched.size()) ? sched[m_pos] : 4'd15;
                if ($urandom_range(0, 24) == 0) ix = 4'($urandom_range(0, 15));
                applyStimulus(st, v, ix);
                nChecks++;
                if (dutVec() !== modelVec()) begin
                    nFails++;
                    $display("[TB] FAIL random run %0d cycle %0d: got %h expected %h", run, c, dutVec(), modelVec());
                end
            end
        end
    endtask

    initial begin
        for (int i = 1; i <= 15; i++) begin
            sched.push_back(4'(i));
            if (i == 4 || i == 13) sched.push_back(4'(i));
        end
        test_reset();
        test_legal_run();
        test_missing_repeat();
        test_gapped_terminal();
        test_restart_priority();
        test_async_reset();
        test_early_late();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hyp_seq_checker.md
# hyp_seq_checker

Consumer-side checker for the hyperbolic CORDIC iteration-index stream driven by the sequence generator in the square-root datapath. It samples the 4-bit index each qualified clock and verifies the hyperbolic schedule: 1..15 with indices 4 and 13 each issued twice. For each accepted step it emits the shift amount and a repeat flag. It reports completion or the first violation with its location, so the datapath and bench both have a single pass/fail source.

## Interface
- IDX_W, 4, index width
- REP_A, 4, first index that must be issued twice
- REP_B, 13, second index that must be issued twice
- LAST, 15, terminal index; generator holds it after completion
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- start  input  1  one-cycle pulse; arms or re-arms the checker
- idx_valid  input  1  idx qualified this cycle
- idx  input  IDX_W  iteration index from generator
- shift_amt  output  IDX_W  index of last accepted step (CORDIC shift)
- shift_vld  output  1  one-cycle pulse per accepted step
- repeat_o  output  1  high with shift_vld when step is the second issue of REP_A/REP_B
- step_cnt  output  5  accepted steps since start (0..17)
- busy  output  1  state is ARMED or RUN
- done  output  1  sticky; full schedule accepted
- err  output  1  sticky; schedule violated
- err_idx  output  IDX_W  offending idx value
- err_step  output  5  step_cnt at the moment of violation

## Operation
- States: IDLE, ARMED, RUN, DONE, ERROR. Internal: exp (expected index, IDX_W bits), rep_seen (1 bit).
- IDLE: idx_valid ignored. start -> ARMED, exp=1, rep_seen=0, step_cnt=0, done=0, err=0.
- ARMED: identical checking to RUN; first accepted step -> RUN. ARMED exists so that busy asserts before any index arrives.
- Check on idx_valid in ARMED/RUN:
  - idx==exp and exp∉{REP_A,REP_B}: accept; exp=exp+1.
  - idx==exp, exp∈{REP_A,REP_B}, rep_seen=0: accept, repeat_o=0; rep_seen=1; exp unchanged.
  - idx==exp, exp∈{REP_A,REP_B}, rep_seen=1: accept, repeat_o=1; rep_seen=0; exp=exp+1.
  - Accept: shift_amt=idx, shift_vld=1, step_cnt+1.
  - Accepted idx==LAST (no repeat pending): -> DONE, done=1.
  - idx!=exp: -> ERROR, err=1, err_idx=idx, err_step=step_cnt (unincremented); no shift_vld.
- DONE: idx_valid with idx==LAST ignored, because the generator freezes on its terminal state. Any other valid idx -> ERROR, err_step=17, done cleared.
- ERROR: sticky; all idx_valid ignored.
- start in any state: re-arm as from IDLE. start has priority over idx_valid in the same cycle; that idx is discarded.
- Arithmetic: exp increment never exceeds LAST, because acceptance of LAST exits RUN. step_cnt saturates at 17 by construction.
- A legal run is exactly 17 steps: 1,2,3,4,4,5,...,12,13,13,14,15.

## Timing
- All outputs registered; response appears the cycle after the idx_valid sample (latency 1).
- shift_vld and repeat_o are single-cycle pulses.
- done, err, err_idx, err_step hold until start or reset.
- idx_valid may be low for any number of cycles between steps; no timeout.
- Reset values (immediate, asynchronous): state=IDLE, shift_amt=0, shift_vld=0, repeat_o=0, step_cnt=0, busy=0, done=0, err=0, err_idx=0, err_step=0.
- Reset mid-run aborts without flagging. After release, the checker needs a new start.
- busy rises the cycle after start. It falls the cycle after the transition to DONE or ERROR.

## Test plan
- Legal run, idx_valid continuous: start, then the 17-step schedule -> 17 shift_vld pulses; repeat_o only on steps 5 (idx 4) and 15 (idx 13); done=1 with step_cnt=17 one cycle after idx 15.
- Missing repeat: 1,2,3,4,5 -> err=1, err_idx=5, err_step=4, no shift_vld for 5; subsequent valid idx ignored.
- Gapped valid plus terminal hold: legal schedule with random 0-5 cycle gaps, then idx=15 held valid for 10 cycles -> identical outputs to the continuous run; done stays 1, err stays 0. Then idx=3 valid -> err=1, err_step=17, done=0.
- Restart priority: start after step 7. Then start coincident with idx_valid, idx=8 -> step_cnt=0, state ARMED, that idx discarded. A fresh legal run then completes with done=1.
- Async reset: assert reset low mid-cycle at step 10 -> all outputs zero before the next clk edge. After release, idx_valid alone has no effect until start.
- Early/late index: start then idx=2 first -> err_idx=2, err_step=0. Separately, start and a legal run to 13,13, then idx=13 a third time -> err_idx=13, err_step=15.
